// File: rtl/dft_mac_sequencer_if.sv
// Purpose: control bundle between the DFT MAC sequencer, its AXI bridge and the MAC datapath.
// Latency: wires only; every signal the master drives comes straight from a register.
// Backpressure: none; start/data_loaded are level handshakes and done is a one-cycle pulse.
// Port summary (master = sequencer side):
//   from bridge : start, sample_num, data_loaded
//   to bridge   : busy, done, err, load_ncompute
//   to datapath : ram_rd_addr, cache_we, cache_wr_addr, cache_rd_addr, tw_k, tw_n,
//                 acc_ce, acc_clr, wb_we, wb_addr
interface dft_mac_sequencer_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic [ADDR_W-1:0] sample_num;
   logic              data_loaded;
   logic              busy;
   logic              done;
   logic              err;
   logic              load_ncompute;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic              cache_we;
   logic [ADDR_W-1:0] cache_wr_addr;
   logic [ADDR_W-1:0] cache_rd_addr;
   logic [ADDR_W-1:0] tw_k;
   logic [ADDR_W-1:0] tw_n;
   logic              acc_ce;
   logic              acc_clr;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;

   modport master (
      input  start, sample_num, data_loaded,
      output busy, done, err, load_ncompute, ram_rd_addr, cache_we, cache_wr_addr,
             cache_rd_addr, tw_k, tw_n, acc_ce, acc_clr, wb_we, wb_addr
   );

   modport slave (
      output start, sample_num, data_loaded,
      input  busy, done, err, load_ncompute, ram_rd_addr, cache_we, cache_wr_addr,
             cache_rd_addr, tw_k, tw_n, acc_ce, acc_clr, wb_we, wb_addr
   );
endinterface

// File: rtl/dft_mac_sequencer.sv
// Purpose: single sequencer for the direct-DFT MAC: RAM->cache fill, k/n double loop, X[k] write-back.
// Latency: (N+1) fill + N*(N+2) compute + 1 done cycles after data_loaded is sampled.
// Backpressure: none; start is ignored while busy, data_loaded is only looked at in WAIT_LOAD.
// Ports: clk, rst (synchronous, active high), bus (dft_mac_sequencer_if.master).
// Optional: define DFT_SEQ_PERF_CNT_EN to add parameter CNT_W and output perf_cycles[CNT_W],
//           a saturating count of busy cycles, cleared on each accepted start.
module dft_mac_sequencer #(
   parameter int ADDR_W = 12
`ifdef DFT_SEQ_PERF_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic                clk,
   input  logic                rst,
   dft_mac_sequencer_if.master bus
`ifdef DFT_SEQ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    perf_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOAD,
      S_FILL,
      S_ISSUE,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] num;        // latched transform length N
   logic [ADDR_W-1:0] fill_idx;   // FILL cycle index, 0..N
   logic              issue_vld;  // cache_rd_addr carries a live n this cycle
   logic [ADDR_W-1:0] last_idx;
   logic              start_acc;

   assign last_idx  = num - ADDR_W'(1);
   assign start_acc = (state == S_IDLE) && bus.start && (bus.sample_num != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         num               <= '0;
         fill_idx          <= '0;
         issue_vld         <= 1'b0;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
         bus.err           <= 1'b0;
         bus.load_ncompute <= 1'b1;
         bus.ram_rd_addr   <= '0;
         bus.cache_we      <= 1'b0;
         bus.cache_wr_addr <= '0;
         bus.cache_rd_addr <= '0;
         bus.tw_k          <= '0;
         bus.tw_n          <= '0;
         bus.acc_ce        <= 1'b0;
         bus.acc_clr       <= 1'b0;
         bus.wb_we         <= 1'b0;
         bus.wb_addr       <= '0;
      end else begin
         bus.done     <= 1'b0;
         bus.cache_we <= 1'b0;
         bus.acc_clr  <= 1'b0;
         bus.wb_we    <= 1'b0;
         issue_vld    <= 1'b0;
         // Cache read data arrives one cycle after its address, so the twiddle
         // n index and the accumulate enable trail the issued n by one cycle.
         bus.acc_ce   <= issue_vld;
         bus.tw_n     <= bus.cache_rd_addr;

         case (state)
            S_IDLE: begin
               if (start_acc) begin
                  num      <= bus.sample_num;
                  bus.err  <= 1'b0;
                  bus.busy <= 1'b1;
                  state    <= S_WAIT_LOAD;
               end else if (bus.start) begin
                  // N==0: flag it and still hand the bridge a done so it does not stall
                  bus.err  <= 1'b1;
                  bus.done <= 1'b1;
               end
            end

            S_WAIT_LOAD: begin
               if (bus.data_loaded) begin
                  fill_idx        <= '0;
                  bus.ram_rd_addr <= '0;
                  state           <= S_FILL;
               end
            end

            // Cycle i reads RAM[i] (i<N) and writes cache[i-1] (i>=1) from the
            // previous read, which returns one cycle later.
            S_FILL: begin
               if (fill_idx == num) begin
                  bus.load_ncompute <= 1'b0;
                  bus.tw_k          <= '0;
                  bus.cache_rd_addr <= '0;
                  bus.acc_clr       <= 1'b1;
                  issue_vld         <= 1'b1;
                  state             <= S_ISSUE;
               end else begin
                  fill_idx          <= fill_idx + ADDR_W'(1);
                  if (fill_idx != last_idx) begin
                     bus.ram_rd_addr <= fill_idx + ADDR_W'(1);
                  end
                  bus.cache_we      <= 1'b1;
                  bus.cache_wr_addr <= fill_idx;
               end
            end

            S_ISSUE: begin
               if (bus.cache_rd_addr == last_idx) begin
                  bus.cache_rd_addr <= '0;
                  state             <= S_DRAIN;
               end else begin
                  bus.cache_rd_addr <= bus.cache_rd_addr + ADDR_W'(1);
                  issue_vld         <= 1'b1;
               end
            end

            // The last product accumulates here; the write-back cycle then clears
            // the accumulator on the same edge RAM captures it.
            S_DRAIN: begin
               bus.wb_we   <= 1'b1;
               bus.wb_addr <= bus.tw_k;
               bus.acc_clr <= 1'b1;
               state       <= S_WRITE;
            end

            S_WRITE: begin
               if (bus.tw_k == last_idx) begin
                  bus.tw_k          <= '0;
                  bus.done          <= 1'b1;
                  bus.load_ncompute <= 1'b1;
                  state             <= S_DONE;
               end else begin
                  bus.tw_k  <= bus.tw_k + ADDR_W'(1);
                  issue_vld <= 1'b1;
                  state     <= S_ISSUE;
               end
            end

            S_DONE: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end

            default: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

`ifdef DFT_SEQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles <= '0;
      end else if (start_acc) begin
         perf_cycles <= '0;
      end else if (bus.busy && (perf_cycles != '1)) begin
         perf_cycles <= perf_cycles + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_dft_mac_sequencer.sv
// Bench for dft_mac_sequencer: drives the bridge side, models RAM, cache,
// twiddle ROM and accumulator around the control outputs, and scores fill
// addresses, written X[k] values and done timing against queued expectations.
module tb_dft_mac_sequencer;
   localparam int ADDR_W = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dft_mac_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef DFT_SEQ_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   dft_mac_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DFT_SEQ_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Quarter-turn twiddles: exact for N in {1,2,4}, scaled by 0x7FFF.
   function automatic int tw_re(input int k, input int n, input int nn);
      int q;
      if (nn == 0) return 0;
      q = ((k * n * 4) / nn) % 4;
      case (q)
         0: return 32767;
         2: return -32767;
         default: return 0;
      endcase
   endfunction

   function automatic int tw_im(input int k, input int n, input int nn);
      int q;
      if (nn == 0) return 0;
      q = ((k * n * 4) / nn) % 4;
      case (q)
         1: return -32767;
         3: return 32767;
         default: return 0;
      endcase
   endfunction

   typedef struct {
      int     addr;
      longint re;
      longint im;
   } wb_exp_t;

   int      exp_cwa[$];
   wb_exp_t exp_wb[$];
   longint  exp_done[$];

   // Datapath model
   int     ram_m   [0:15];
   int     cache_m [0:15];
   int     ram_q   = 0;
   int     cache_q = 0;
   longint acc_re  = 0;
   longint acc_im  = 0;
   int     cur_n   = 0;
   longint cyc     = 0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      ram_q   <= ram_m[bus.ram_rd_addr[3:0]];
      cache_q <= cache_m[bus.cache_rd_addr[3:0]];
      if (bus.cache_we) cache_m[bus.cache_wr_addr[3:0]] <= ram_q;
      if (bus.acc_clr) begin
         acc_re <= 0;
         acc_im <= 0;
      end else if (bus.acc_ce) begin
         acc_re <= acc_re + longint'(cache_q) * tw_re(int'(bus.tw_k), int'(bus.tw_n), cur_n);
         acc_im <= acc_im + longint'(cache_q) * tw_im(int'(bus.tw_k), int'(bus.tw_n), cur_n);
      end
   end

   // Monitor / scoreboard
   int prev_rra = 0;
   int prev_cra = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      int      e;
      wb_exp_t w;
      longint  dc;
      if (!rst) begin
         chk("ce_clr_excl", bus.acc_ce & bus.acc_clr, 0);
         chk("wb_while_load", bus.wb_we & bus.load_ncompute, 0);
         if (bus.cache_we) begin
            chk("cache_we_expected", exp_cwa.size() != 0, 1);
            if (exp_cwa.size() != 0) begin
               e = exp_cwa.pop_front();
               chk("cache_wr_addr", bus.cache_wr_addr, e);
               chk("ram_rd_prev", prev_rra, e);
            end
         end
         if (bus.acc_ce) chk("tw_n_align", bus.tw_n, prev_cra);
         if (bus.wb_we) begin
            chk("wb_we_expected", exp_wb.size() != 0, 1);
            if (exp_wb.size() != 0) begin
               w = exp_wb.pop_front();
               chk("wb_addr", bus.wb_addr, w.addr);
               chk("X_re", acc_re, w.re);
               chk("X_im", acc_im, w.im);
            end
         end
         if (bus.done) begin
            done_cnt++;
            chk("done_expected", exp_done.size() != 0, 1);
            chk("done_load_mode", bus.load_ncompute, 1);
            if (exp_done.size() != 0) begin
               dc = exp_done.pop_front();
               chk("done_cycle", cyc, dc);
            end
         end
      end
      prev_rra = int'(bus.ram_rd_addr);
      prev_cra = int'(bus.cache_rd_addr);
   end

   task automatic set_ram(input int a, input int b, input int c, input int d);
      for (int i = 0; i < 16; i++) ram_m[i] = 0;
      ram_m[0] = a;
      ram_m[1] = b;
      ram_m[2] = c;
      ram_m[3] = d;
   endtask

   // One full transform of length n; data_loaded is raised dl_delay cycles
   // into WAIT_LOAD. mid_start re-pulses start with N=16 in the first ISSUE cycle.
   task automatic run(input int n, input int dl_delay, input bit mid_start);
      longint s;
      longint c;
      int     d0;
      cur_n = n;
      for (int i = 0; i < n; i++) exp_cwa.push_back(i);
      for (int k = 0; k < n; k++) begin
         wb_exp_t w;
         w.addr = k;
         w.re   = 0;
         w.im   = 0;
         for (int j = 0; j < n; j++) begin
            w.re += longint'(ram_m[j]) * tw_re(k, j, n);
            w.im += longint'(ram_m[j]) * tw_im(k, j, n);
         end
         exp_wb.push_back(w);
      end
      d0 = done_cnt;
      bus.start      = 1'b1;
      bus.sample_num = ADDR_W'(n);
      s = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      chk("wait_busy", bus.busy, 1);
      chk("wait_err", bus.err, 0);
      chk("wait_load_mode", bus.load_ncompute, 1);
      repeat (dl_delay) @(negedge clk);
      bus.data_loaded = 1'b1;
      c = cyc;
      exp_done.push_back(c + (n + 1) + n * (n + 2) + 1);
      @(negedge clk);
      bus.data_loaded = 1'b0;
      repeat (n + 1) @(negedge clk);
      chk("issue_load_mode", bus.load_ncompute, 0);
      chk("issue_acc_clr", bus.acc_clr, 1);
      chk("issue_rd_addr", bus.cache_rd_addr, 0);
      chk("issue_tw_k", bus.tw_k, 0);
      if (mid_start) begin
         bus.start      = 1'b1;
         bus.sample_num = ADDR_W'(16);
         @(negedge clk);
         bus.start      = 1'b0;
         bus.sample_num = ADDR_W'(n);
      end
      for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
      chk("done_seen", done_cnt - d0, 1);
      @(negedge clk);
      chk("end_busy", bus.busy, 0);
      chk("end_load_mode", bus.load_ncompute, 1);
      chk("end_wb_left", exp_wb.size(), 0);
      chk("end_cwa_left", exp_cwa.size(), 0);
`ifdef DFT_SEQ_PERF_CNT_EN
      chk("perf_cycles", perf_cycles, (c - s) + (n + 1) + n * (n + 2) + 1);
`endif
      exp_wb.delete();
      exp_cwa.delete();
      exp_done.delete();
   endtask

   initial begin
      int d0;
      rst             = 1'b1;
      bus.start       = 1'b0;
      bus.sample_num  = '0;
      bus.data_loaded = 1'b0;
      set_ram(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cache_m[i] = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_load_mode", bus.load_ncompute, 1);
      chk("rst_cache_we", bus.cache_we, 0);
      chk("rst_acc_ce", bus.acc_ce, 0);
      chk("rst_acc_clr", bus.acc_clr, 0);
      chk("rst_wb_we", bus.wb_we, 0);
      chk("rst_ram_rd_addr", bus.ram_rd_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      // data_loaded seen while idle must not carry into the next run
      bus.data_loaded = 1'b1;
      @(negedge clk);
      bus.data_loaded = 1'b0;
      @(negedge clk);
      chk("idle_dl_busy", bus.busy, 0);

      set_ram(1, 0, 0, 0);
      run(4, 2, 1'b0);
      set_ram(3, -1, 2, 5);
      run(4, 0, 1'b1);
      set_ram(7, 0, 0, 0);
      run(1, 1, 1'b0);

      // N==0: error flag plus a lone done pulse, never busy
      d0 = done_cnt;
      bus.start      = 1'b1;
      bus.sample_num = '0;
      exp_done.push_back(cyc + 1);
      @(negedge clk);
      bus.start = 1'b0;
      chk("zero_err", bus.err, 1);
      chk("zero_busy", bus.busy, 0);
      chk("zero_done", bus.done, 1);
      @(negedge clk);
      chk("zero_err_sticky", bus.err, 1);
      chk("zero_done_pulse", bus.done, 0);
      chk("zero_busy_after", bus.busy, 0);
      chk("zero_done_count", done_cnt - d0, 1);
      set_ram(2, -3, 0, 0);
      run(2, 0, 1'b0);

      // Reset in the middle of ISSUE with N=8
      set_ram(1, 1, 1, 1);
      cur_n = 8;
      for (int i = 0; i < 8; i++) exp_cwa.push_back(i);
      bus.start      = 1'b1;
      bus.sample_num = ADDR_W'(8);
      @(negedge clk);
      bus.start       = 1'b0;
      bus.data_loaded = 1'b1;
      @(negedge clk);
      bus.data_loaded = 1'b0;
      repeat (12) @(negedge clk);
      chk("pre_rst_load_mode", bus.load_ncompute, 0);
      chk("pre_rst_cwa_used", exp_cwa.size(), 0);
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_acc_ce", bus.acc_ce, 0);
      chk("abort_wb_we", bus.wb_we, 0);
      chk("abort_cache_we", bus.cache_we, 0);
      chk("abort_load_mode", bus.load_ncompute, 1);
      chk("abort_done", bus.done, 0);
      exp_cwa.delete();
      exp_wb.delete();
      exp_done.delete();
      repeat (40) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_still_idle", bus.busy, 0);

      set_ram(4, 0, -4, 1);
      run(4, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
